// File: rtl/passcode_verifier_n_pkg.sv
// Shared types for the passcode verifier: FSM state encoding and
// Pass_Fail_Out result codes.
package passcode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PASS,
    ST_FAIL,
    ST_LOCKED
  } state_e;

  localparam logic [1:0] PF_IDLE = 2'b00;
  localparam logic [1:0] PF_PASS = 2'b01;
  localparam logic [1:0] PF_FAIL = 2'b10;
  localparam logic [1:0] PF_LOCK = 2'b11;

endpackage

// File: rtl/passcode_verifier_n_if.sv
// Digit entry / result bundle between the front end (master) and the
// passcode verifier (slave).
interface passcode_verifier_n_if #(
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MAX_TRIES  = 3
);
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  logic                           Enable_In;
  logic                           Digit_Valid;
  logic [DIGIT_W-1:0]             Digit_In;
  logic                           Clear;
  logic [NUM_DIGITS*DIGIT_W-1:0]  Ref_Code;
  logic [1:0]                     Pass_Fail_Out;
  logic [CW-1:0]                  Digit_Count;
  logic [TW-1:0]                  Tries_Left;

  modport master (
    output Enable_In, Digit_Valid, Digit_In, Clear, Ref_Code,
    input  Pass_Fail_Out, Digit_Count, Tries_Left
  );

  modport slave (
    input  Enable_In, Digit_Valid, Digit_In, Clear, Ref_Code,
    output Pass_Fail_Out, Digit_Count, Tries_Left
  );
endinterface

// File: rtl/passcode_verifier_n_down_counter.sv
// Loadable, enable-gated down counter that saturates at zero and flags it.
module passcode_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (en_i) begin
      if (load_i) begin
        count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
        count_q <= count_q - W'(1);
      end
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/passcode_verifier_n.sv
// Parametrised passcode verifier with failed-attempt lockout.
// Optional inter-digit timeout enabled by defining PASSCODE_TIMEOUT_EN.
module passcode_verifier_n
  import passcode_pkg::*;
#(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  passcode_verifier_n_if.slave  bus
);
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

  state_e        state_q;
  logic [1:0]    pf_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tries_q;
  logic          mism_q;

  logic [CW-1:0]      exp_idx;
  logic [DIGIT_W-1:0] exp_digit;
  logic               accept, last_digit, mism_final, timed_out, fail_now;
  logic               lock_load, lock_zero;

  // Start of a new entry always compares against digit 0, regardless of count.
  always_comb begin
    exp_idx   = (state_q == ST_COLLECT) ? cnt_q : '0;
    exp_digit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (exp_idx == i[CW-1:0]) begin
        exp_digit = bus.Ref_Code[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
    accept     = bus.Digit_Valid && !bus.Clear && (state_q != ST_LOCKED);
    last_digit = accept && (exp_idx == CW'(NUM_DIGITS - 1));
    mism_final = (bus.Digit_In != exp_digit) || ((state_q == ST_COLLECT) && mism_q);
    fail_now   = (last_digit && mism_final) || timed_out;
    lock_load  = fail_now && (tries_q == TW'(1));
  end

`ifdef PASSCODE_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic to_zero;

  passcode_down_counter #(.W(TOW)) u_timeout_cnt (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .en_i       (bus.Enable_In),
    .load_i     (accept),
    .load_val_i (TOW'(TIMEOUT_CYCLES - 1)),
    .dec_i      (state_q == ST_COLLECT),
    .zero_o     (to_zero)
  );

  // An arriving digit or Clear in the expiry cycle takes priority over timeout.
  assign timed_out = (state_q == ST_COLLECT) && !accept && !bus.Clear && to_zero;
`else
  assign timed_out = 1'b0;
`endif

  passcode_down_counter #(.W(LW)) u_lock_cnt (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .en_i       (bus.Enable_In),
    .load_i     (lock_load),
    .load_val_i (LW'(LOCKOUT_CYCLES - 1)),
    .dec_i      (state_q == ST_LOCKED),
    .zero_o     (lock_zero)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      pf_q    <= PF_IDLE;
      cnt_q   <= '0;
      tries_q <= TW'(MAX_TRIES);
      mism_q  <= 1'b0;
    end else if (bus.Enable_In) begin
      if (state_q == ST_LOCKED) begin
        if (lock_zero) begin
          state_q <= ST_IDLE;
          pf_q    <= PF_IDLE;
          tries_q <= TW'(MAX_TRIES);
        end
      end else if (bus.Clear) begin
        state_q <= ST_IDLE;
        pf_q    <= PF_IDLE;
        cnt_q   <= '0;
        mism_q  <= 1'b0;
      end else if (fail_now) begin
        mism_q <= 1'b0;
        if (tries_q == TW'(1)) begin
          state_q <= ST_LOCKED;
          pf_q    <= PF_LOCK;
          cnt_q   <= '0;
          tries_q <= '0;
        end else begin
          state_q <= ST_FAIL;
          pf_q    <= PF_FAIL;
          cnt_q   <= CW'(NUM_DIGITS);
          tries_q <= tries_q - TW'(1);
        end
      end else if (last_digit) begin
        state_q <= ST_PASS;
        pf_q    <= PF_PASS;
        cnt_q   <= CW'(NUM_DIGITS);
        tries_q <= TW'(MAX_TRIES);
        mism_q  <= 1'b0;
      end else if (accept) begin
        state_q <= ST_COLLECT;
        pf_q    <= PF_IDLE;
        cnt_q   <= exp_idx + CW'(1);
        mism_q  <= mism_final;
      end
    end
  end

  assign bus.Pass_Fail_Out = pf_q;
  assign bus.Digit_Count   = cnt_q;
  assign bus.Tries_Left    = tries_q;
endmodule

// File: tb/tb_passcode_verifier_n.sv
// Directed self-checking bench for passcode_verifier_n (code 6728, 3 tries,
// 20-cycle lockout; timeout scenario when PASSCODE_TIMEOUT_EN is defined).
module tb_passcode_verifier_n;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   checks_total  = 0;
  int   checks_passed = 0;

  passcode_verifier_n_if #(.DIGIT_W(4), .NUM_DIGITS(4), .MAX_TRIES(3)) bus ();

  passcode_verifier_n #(
    .DIGIT_W        (4),
    .NUM_DIGITS     (4),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (20),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic send_digit(input logic [3:0] d);
    @(negedge Clk);
    bus.Digit_Valid = 1'b1;
    bus.Digit_In    = d;
    @(negedge Clk);
    bus.Digit_Valid = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 3; i >= 0; i--) send_digit(c[i*4 +: 4]);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00) $display("FAIL reset_pf: got %b required 00", bus.Pass_Fail_Out);
    else checks_passed++;
    checks_total++;
    if (bus.Digit_Count !== 3'd0) $display("FAIL reset_cnt: got %0d required 0", bus.Digit_Count);
    else checks_passed++;
    checks_total++;
    if (bus.Tries_Left !== 2'd3) $display("FAIL reset_tries: got %0d required 3", bus.Tries_Left);
    else checks_passed++;
    Rst = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_pass();
    send_digit(4'h6);
    send_digit(4'h7);
    checks_total++;
    if (bus.Digit_Count !== 3'd2) $display("FAIL mid_cnt: got %0d required 2", bus.Digit_Count);
    else checks_passed++;
    send_digit(4'h2);
    send_digit(4'h8);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b01) $display("FAIL pass_pf: got %b required 01", bus.Pass_Fail_Out);
    else checks_passed++;
    checks_total++;
    if (bus.Tries_Left !== 2'd3) $display("FAIL pass_tries: got %0d required 3", bus.Tries_Left);
    else checks_passed++;
    checks_total++;
    if (bus.Digit_Count !== 3'd4) $display("FAIL pass_cnt: got %0d required 4", bus.Digit_Count);
    else checks_passed++;
    repeat (3) @(negedge Clk);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b01) $display("FAIL pass_hold: got %b required 01", bus.Pass_Fail_Out);
    else checks_passed++;
    send_digit(4'h6);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00 || bus.Digit_Count !== 3'd1)
      $display("FAIL restart_from_pass: got pf=%b cnt=%0d required pf=00 cnt=1", bus.Pass_Fail_Out, bus.Digit_Count);
    else checks_passed++;
    @(negedge Clk);
    bus.Clear = 1'b1;
    @(negedge Clk);
    bus.Clear = 1'b0;
  endtask

  task automatic test_lockout();
    enter_code(16'h6729);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b10 || bus.Tries_Left !== 2'd2)
      $display("FAIL fail1: got pf=%b tries=%0d required pf=10 tries=2", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
    enter_code(16'h1728);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b10 || bus.Tries_Left !== 2'd1)
      $display("FAIL fail2: got pf=%b tries=%0d required pf=10 tries=1", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
    enter_code(16'h6028);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b11 || bus.Tries_Left !== 2'd0 || bus.Digit_Count !== 3'd0)
      $display("FAIL lock_enter: got pf=%b tries=%0d cnt=%0d required pf=11 tries=0 cnt=0",
               bus.Pass_Fail_Out, bus.Tries_Left, bus.Digit_Count);
    else checks_passed++;
    for (int k = 1; k <= 19; k++) begin
      @(negedge Clk);
      if (k == 10 || k == 19) begin
        checks_total++;
        if (bus.Pass_Fail_Out !== 2'b11 || bus.Digit_Count !== 3'd0)
          $display("FAIL lock_hold_%0d: got pf=%b cnt=%0d required pf=11 cnt=0", k, bus.Pass_Fail_Out, bus.Digit_Count);
        else checks_passed++;
      end
      bus.Digit_Valid = (k == 3 || k == 4 || k == 8);
      bus.Digit_In    = 4'h6;
      bus.Clear       = (k == 6);
    end
    @(negedge Clk);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00 || bus.Tries_Left !== 2'd3)
      $display("FAIL lock_exit: got pf=%b tries=%0d required pf=00 tries=3", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
  endtask

  task automatic test_pass_reload();
    enter_code(16'h6729);
    enter_code(16'h0000);
    checks_total++;
    if (bus.Tries_Left !== 2'd1) $display("FAIL reload_pre: got %0d required 1", bus.Tries_Left);
    else checks_passed++;
    enter_code(16'h6728);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b01 || bus.Tries_Left !== 2'd3)
      $display("FAIL reload_pass: got pf=%b tries=%0d required pf=01 tries=3", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
  endtask

  task automatic test_clear();
    enter_code(16'h6720);
    send_digit(4'h6);
    send_digit(4'h7);
    @(negedge Clk);
    bus.Clear       = 1'b1;
    bus.Digit_Valid = 1'b1;
    bus.Digit_In    = 4'h2;
    @(negedge Clk);
    bus.Clear       = 1'b0;
    bus.Digit_Valid = 1'b0;
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00 || bus.Digit_Count !== 3'd0 || bus.Tries_Left !== 2'd2)
      $display("FAIL clear: got pf=%b cnt=%0d tries=%0d required pf=00 cnt=0 tries=2",
               bus.Pass_Fail_Out, bus.Digit_Count, bus.Tries_Left);
    else checks_passed++;
    enter_code(16'h6728);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b01 || bus.Tries_Left !== 2'd3)
      $display("FAIL clear_then_pass: got pf=%b tries=%0d required pf=01 tries=3", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
  endtask

  task automatic test_enable_freeze();
    enter_code(16'h0000);
    enter_code(16'h0000);
    enter_code(16'h0000);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b11) $display("FAIL freeze_lock: got %b required 11", bus.Pass_Fail_Out);
    else checks_passed++;
    for (int k = 1; k <= 29; k++) begin
      @(negedge Clk);
      if (k == 2)  bus.Enable_In = 1'b0;
      if (k == 12) bus.Enable_In = 1'b1;
    end
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b11) $display("FAIL freeze_still_locked: got %b required 11", bus.Pass_Fail_Out);
    else checks_passed++;
    @(negedge Clk);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00 || bus.Tries_Left !== 2'd3)
      $display("FAIL freeze_exit: got pf=%b tries=%0d required pf=00 tries=3", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
  endtask

  task automatic test_async_reset();
    enter_code(16'h1111);
    send_digit(4'h6);
    send_digit(4'h7);
    #2;
    Rst = 1'b0;
    #1;
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00 || bus.Digit_Count !== 3'd0 || bus.Tries_Left !== 2'd3)
      $display("FAIL async_reset: got pf=%b cnt=%0d tries=%0d required pf=00 cnt=0 tries=3",
               bus.Pass_Fail_Out, bus.Digit_Count, bus.Tries_Left);
    else checks_passed++;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
  endtask

`ifdef PASSCODE_TIMEOUT_EN
  task automatic test_timeout();
    send_digit(4'h6);
    send_digit(4'h7);
    for (int k = 1; k <= 49; k++) @(negedge Clk);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00) $display("FAIL timeout_early: got %b required 00", bus.Pass_Fail_Out);
    else checks_passed++;
    @(negedge Clk);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b10 || bus.Tries_Left !== 2'd2)
      $display("FAIL timeout_fire: got pf=%b tries=%0d required pf=10 tries=2", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
    send_digit(4'h6);
    send_digit(4'h7);
    for (int k = 1; k <= 49; k++) begin
      @(negedge Clk);
      if (k == 49) begin
        bus.Digit_Valid = 1'b1;
        bus.Digit_In    = 4'h2;
      end
    end
    @(negedge Clk);
    bus.Digit_Valid = 1'b0;
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b00 || bus.Digit_Count !== 3'd3)
      $display("FAIL timeout_digit_wins: got pf=%b cnt=%0d required pf=00 cnt=3", bus.Pass_Fail_Out, bus.Digit_Count);
    else checks_passed++;
    send_digit(4'h8);
    checks_total++;
    if (bus.Pass_Fail_Out !== 2'b01 || bus.Tries_Left !== 2'd3)
      $display("FAIL timeout_then_pass: got pf=%b tries=%0d required pf=01 tries=3", bus.Pass_Fail_Out, bus.Tries_Left);
    else checks_passed++;
  endtask
`endif

  initial begin
    bus.Enable_In   = 1'b1;
    bus.Digit_Valid = 1'b0;
    bus.Digit_In    = 4'h0;
    bus.Clear       = 1'b0;
    bus.Ref_Code    = 16'h6728;
    test_reset();
    test_pass();
    test_lockout();
    test_pass_reload();
    test_clear();
    test_enable_freeze();
    test_async_reset();
`ifdef PASSCODE_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
